seg_scan_decoder: RTL
=====================

// Module: seg_scan_decoder
// PURPOSE
//  Reader side of the seven-segment display interface. Samples a multiplexed
//  display bus (active-low one-hot anode select + active-low segments), waits
//  for each digit pattern to be stable, decodes it back to a hex nibble and
//  assembles a full multi-digit word. Used for loopback self-test of the
//  display path and for reading scanned displays back into logic.
// PARAMETERS
//  DIGITS          4   number of multiplexed digits (value width = 4*DIGITS)
//  STABLE_CYCLES   4   consecutive identical samples required to accept a digit (>=2)
//  TIMEOUT_CYCLES  4096 cycles without an accepted digit before partial frame is dropped
// PORTS
//  clk          in   1          system clock, rising edge
//  rst          in   1          asynchronous reset, active-high
//  an_in        in   DIGITS     anode select, active-low, one-hot; bit i = digit i
//  seg_in       in   7          segments, active-low; [6]=a,[5]=b,[4]=c,[3]=d,[2]=e,[1]=f,[0]=g
//  value        out  4*DIGITS   last complete frame; digit i at value[4i+3:4i]
//  frame_valid  out  1          1-cycle pulse when value/frame_err update
//  frame_err    out  1          >=1 digit of last frame had an undecodable pattern
//  stale        out  1          timeout occurred since last frame_valid
// BEHAVIOUR
//  - Reset: value=0, frame_valid=0, frame_err=0, stale=0, mask/err bits=0,
//    counters=0, FSM=COLLECT. Reset mid-frame discards all partial digits.
//  - an_in/seg_in pass a 2-flop synchronizer; all rules below use synced samples.
//  - Stability: sample pair {an,seg} equal to previous -> cnt++ (saturate at
//    STABLE_CYCLES); differs -> cnt=0. Capture fires exactly once per dwell, on
//    the cycle cnt reaches STABLE_CYCLES-1 (pair seen STABLE_CYCLES times).
//  - Illegal an (all high = blank, or >1 low): no capture; counts as a change.
//  - Decode: exact inverse of the team hex->segment table (0..9, A..F; e.g.
//    0=0000001, 1=1001111, 3=0000110, 8=0000000, A=0001000, F=0111000).
//    Any other pattern -> nibble 4'h0, err bit for that digit set.
//  - Capture of digit i: nibble_reg[i], err_reg[i] written, mask[i]=1. Repeat
//    capture of same digit before frame completes overwrites (latest wins).
//  - FSM COLLECT: when mask becomes all-ones -> EMIT next cycle.
//    EMIT (1 cycle): frame_valid=1, value<=nibble_regs, frame_err<=|err_reg,
//    stale<=0, mask/err cleared -> COLLECT. A capture landing in EMIT is
//    applied after the clear (counts toward the next frame).
//  - Latency: last digit's capture edge -> frame_valid high on following cycle;
//    input edge -> capture = 2 (sync) + STABLE_CYCLES-1 cycles.
//  - Timeout: idle counter clears on every capture; in COLLECT with mask!=0
//    and counter reaching TIMEOUT_CYCLES -> mask/err cleared, stale=1 (level,
//    held until next frame_valid). value keeps previous frame.
//  - value/frame_err change only in EMIT; stable otherwise.
// TESTING (DIGITS=4, STABLE_CYCLES=4, TIMEOUT_CYCLES=64)
//  1 Scan an=1110/1101/1011/0111 with seg=0000110,0000001,0001000,0111000, 8 cyc
//    each -> one frame_valid pulse, value=16'hFA03, frame_err=0.
//  2 Hold digit0 pair only 3 cycles between changes -> no capture, no frame_valid.
//  3 Full scan with digit2 seg=1111111 -> frame_valid, value[11:8]=0, frame_err=1.
//  4 an=1100 or 1111 held 20 cycles mid-scan -> mask unchanged, no capture.
//  5 Capture digits 0,1 then idle 64 cycles -> stale=1, mask=0; next full scan
//    -> frame_valid, stale=0, value updated.
//  6 Assert rst after 3 digits captured -> all outputs 0 at once; after release
//    frame_valid only after 4 fresh digit captures.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Reader for a multiplexed seven-segment bus. Each digit pattern must hold for
// STABLE_CYCLES synced samples before it is decoded; a full set of digits forms one frame.
module seg_scan_decoder #(
  parameter int DIGITS         = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DIGITS-1:0]   an_in,
  input  logic [6:0]          seg_in,
  output logic [4*DIGITS-1:0] value,
  output logic                frame_valid,
  output logic                frame_err,
  output logic                stale
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {COLLECT, EMIT} state_t;
  state_t state, state_nxt;

  logic [DIGITS-1:0]   an_s1, an_s2, an_prev;
  logic [6:0]          seg_s1, seg_s2, seg_prev;
  logic [CW-1:0]       cnt;
  logic [TW-1:0]       idle_cnt;
  logic [DIGITS-1:0]   sel, mask, err_reg, cap_bits;
  logic [3:0]          nibble_reg [DIGITS];
  logic [4*DIGITS-1:0] nib_flat;
  logic                sel_legal, same, cap, timeout, dec_err;
  logic [3:0]          dec_nib;

  // Sync flops idle at the blank pattern so reset never looks like a digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_s1    <= '1;
      an_s2    <= '1;
      an_prev  <= '1;
      seg_s1   <= '1;
      seg_s2   <= '1;
      seg_prev <= '1;
    end else begin
      an_s1    <= an_in;
      an_s2    <= an_s1;
      an_prev  <= an_s2;
      seg_s1   <= seg_in;
      seg_s2   <= seg_s1;
      seg_prev <= seg_s2;
    end
  end

  assign sel       = ~an_s2;
  assign sel_legal = (sel != '0) && ((sel & (sel - DIGITS'(1))) == '0);
  assign same      = ({an_s2, seg_s2} == {an_prev, seg_prev});
  assign cap       = sel_legal && same && (cnt == CW'(STABLE_CYCLES - 2));
  assign cap_bits  = cap ? sel : '0;
  assign timeout   = (state == COLLECT) && (mask != '0) && !cap &&
                     (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      idle_cnt <= '0;
    end else begin
      if (!sel_legal || !same)
        cnt <= '0;
      else if (cnt != CW'(STABLE_CYCLES))
        cnt <= cnt + CW'(1);
      if (cap)
        idle_cnt <= '0;
      else if (idle_cnt != TW'(TIMEOUT_CYCLES))
        idle_cnt <= idle_cnt + TW'(1);
    end
  end

  // Active-low segment patterns, bit 6 = a ... bit 0 = g.
  always_comb begin
    dec_nib = 4'h0;
    dec_err = 1'b0;
    case (seg_s2)
      7'h01: dec_nib = 4'h0;
      7'h4F: dec_nib = 4'h1;
      7'h12: dec_nib = 4'h2;
      7'h06: dec_nib = 4'h3;
      7'h4C: dec_nib = 4'h4;
      7'h24: dec_nib = 4'h5;
      7'h20: dec_nib = 4'h6;
      7'h0F: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h04: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h60: dec_nib = 4'hB;
      7'h31: dec_nib = 4'hC;
      7'h42: dec_nib = 4'hD;
      7'h30: dec_nib = 4'hE;
      7'h38: dec_nib = 4'hF;
      default: dec_err = 1'b1;
    endcase
  end

  always_comb begin
    for (int i = 0; i < DIGITS; i++)
      nib_flat[4*i +: 4] = nibble_reg[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= COLLECT;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    frame_valid = 1'b0;
    case (state)
      COLLECT: if (&mask) state_nxt = EMIT;
      EMIT: begin
        frame_valid = 1'b1;
        state_nxt   = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // Frame outputs load on entry to EMIT so they are valid alongside the pulse;
  // the mask clear happens on the way out, keeping any capture made during EMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DIGITS; i++)
        nibble_reg[i] <= 4'h0;
      mask      <= '0;
      err_reg   <= '0;
      value     <= '0;
      frame_err <= 1'b0;
      stale     <= 1'b0;
    end else begin
      for (int i = 0; i < DIGITS; i++)
        if (cap_bits[i])
          nibble_reg[i] <= dec_nib;
      if (state == EMIT) begin
        mask    <= cap_bits;
        err_reg <= cap_bits & {DIGITS{dec_err}};
      end else if (timeout) begin
        mask    <= '0;
        err_reg <= '0;
      end else begin
        mask    <= mask | cap_bits;
        err_reg <= (err_reg & ~cap_bits) | (cap_bits & {DIGITS{dec_err}});
      end
      if ((state == COLLECT) && (&mask)) begin
        value     <= nib_flat;
        frame_err <= |err_reg;
        stale     <= 1'b0;
      end else if (timeout) begin
        stale <= 1'b1;
      end
    end
  end

endmodule
